// File: rtl/write_track_buffer.sv
// write_track_buffer: in-order tracker of outstanding bus writes with read-hazard check and drain fence.
// Define WRITE_TRACK_UNDERFLOW_ERR_EN to make err a sticky flag for wr_done arriving while empty.
module write_track_buffer #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 32,
  parameter int BURST_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_req_valid,
  input  logic [ADDR_W-1:0]          wr_req_addr,
  output logic                       wr_req_ready,
  input  logic                       wr_done,
  input  logic [ADDR_W-1:0]          rd_check_addr,
  output logic                       rd_conflict,
  input  logic                       drain_req,
  output logic                       drain_ack,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       err
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int LSB = BURST_W + 2;
  localparam int TW  = ADDR_W - LSB;
  typedef enum logic {TRACK, DRAIN} state_t;
  state_t          r_state;
  logic [TW-1:0]   r_mem [DEPTH];
  logic [PW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_acc, w_ret, w_unused;
  assign full         = r_count == CW'(DEPTH);
  assign empty        = r_count == '0;
  assign count        = r_count;
  assign wr_req_ready = !rst && !full && r_state == TRACK;
  assign drain_ack    = r_state == DRAIN && empty;
  assign w_acc        = wr_req_valid && wr_req_ready;
  assign w_ret        = wr_done && !empty;
  assign w_unused     = ^{wr_req_addr[LSB-1:0], rd_check_addr[LSB-1:0]};
  // Line-granular hazard match against every live entry; an accept this cycle is not yet live.
  always_comb begin
    rd_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      rd_conflict = rd_conflict | (({1'b0, PW'(i) - r_rptr} < r_count) && r_mem[i] == rd_check_addr[ADDR_W-1:LSB]);
  end
  // Entry storage holds only the line tag; contents are don't-care until counted live.
  always_ff @(posedge clk)
    if (w_acc) r_mem[r_wptr] <= wr_req_addr[ADDR_W-1:LSB];
  // Pointers, occupancy and TRACK/DRAIN state; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_state <= TRACK;
    end else begin
      if (w_acc) r_wptr <= r_wptr + PW'(1);
      if (w_ret) r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_acc) - CW'(w_ret);
      r_state <= drain_req ? DRAIN : TRACK;
    end
`ifdef WRITE_TRACK_UNDERFLOW_ERR_EN
  logic r_err;
  assign err = r_err;
  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst)
    if (rst) r_err <= 1'b0;
    else if (wr_done && empty) r_err <= 1'b1;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_write_track_buffer.sv
// tb_write_track_buffer: directed and random checks of write_track_buffer against a queue model.
module tb_write_track_buffer;
  localparam int DEPTH = 4;
  localparam int LSB   = 4;
`ifdef WRITE_TRACK_UNDERFLOW_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1;
  logic        wr_req_valid = 1'b0, wr_done = 1'b0, drain_req = 1'b0;
  logic [31:0] wr_req_addr = '0, rd_check_addr = '0;
  logic        wr_req_ready, rd_conflict, drain_ack, empty, full, err;
  logic [2:0]  count;
  int          n_cmp = 0, n_err = 0;
  logic [31:0] q[$];
  logic        m_drain = 1'b0, m_err = 1'b0;

  write_track_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .BURST_W(2)) dut (
    .clk(clk), .rst(rst), .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr),
    .wr_req_ready(wr_req_ready), .wr_done(wr_done), .rd_check_addr(rd_check_addr),
    .rd_conflict(rd_conflict), .drain_req(drain_req), .drain_ack(drain_ack),
    .count(count), .empty(empty), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_conf(input logic [31:0] ra);
    foreach (q[i]) if ((q[i] >> LSB) == (ra >> LSB)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_all();
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("ready", 32'(wr_req_ready), 32'(!m_drain && q.size() < DEPTH));
    chk("conflict", 32'(rd_conflict), 32'(m_conf(rd_check_addr)));
    chk("drain_ack", 32'(drain_ack), 32'(m_drain && q.size() == 0));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic step(input logic v, input logic [31:0] a, input logic d, input logic [31:0] ra, input logic dr);
    logic rdy;
    @(negedge clk);
    wr_req_valid = v; wr_req_addr = a; wr_done = d; rd_check_addr = ra; drain_req = dr;
    #1;
    check_all();
    rdy = !m_drain && q.size() < DEPTH;
    @(posedge clk);
    if (d && q.size() == 0) m_err = m_err | ERR_EN;
    if (d && q.size() > 0) void'(q.pop_front());
    if (v && rdy) q.push_back(a);
    m_drain = dr;
    #1;
  endtask

  initial begin
    logic        dr_lvl;
    logic [31:0] base;
    base = 32'h4080_0000;
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ready", 32'(wr_req_ready), 0);
    chk("rst_ack", 32'(drain_ack), 0);
    chk("rst_conflict", 32'(rd_conflict), 0);
    chk("rst_err", 32'(err), 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("post_rst_ready", 32'(wr_req_ready), 1);
    // fill
    for (int i = 0; i < 4; i++) step(1, base + 32'(i * 16), 0, 0, 0);
    chk("fill_count", 32'(count), 4);
    chk("fill_full", 32'(full), 1);
    chk("fill_ready", 32'(wr_req_ready), 0);
    step(1, base + 32'h40, 0, 0, 0);
    chk("fill_held", 32'(count), 4);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
    // hazard
    step(1, base, 0, 0, 0);
    step(1, base + 32'h10, 0, 0, 0);
    step(0, 0, 0, base + 32'h1C, 0);
    chk("haz_hit", 32'(rd_conflict), 1);
    step(0, 0, 0, base + 32'h20, 0);
    chk("haz_miss", 32'(rd_conflict), 0);
    step(0, 0, 1, base + 32'h1C, 0);
    step(0, 0, 1, base + 32'h1C, 0);
    chk("haz_retired", 32'(rd_conflict), 0);
    // simultaneous accept and retire
    step(1, base + 32'h100, 0, 0, 0);
    step(1, base + 32'h200, 0, 0, 0);
    step(1, base + 32'h300, 1, base + 32'h100, 0);
    chk("sim_count", 32'(count), 2);
    chk("sim_old_gone", 32'(rd_conflict), 0);
    step(0, 0, 0, base + 32'h304, 0);
    chk("sim_new_tracked", 32'(rd_conflict), 1);
    // drain
    step(1, base + 32'h400, 0, 0, 0);
    chk("drain_count3", 32'(count), 3);
    step(0, 0, 0, 0, 1);
    chk("drain_ready", 32'(wr_req_ready), 0);
    step(1, base + 32'h500, 1, 0, 1);
    chk("drain_ack1", 32'(drain_ack), 0);
    step(0, 0, 1, 0, 1);
    chk("drain_ack2", 32'(drain_ack), 0);
    step(0, 0, 1, 0, 1);
    chk("drain_ack3", 32'(drain_ack), 1);
    chk("drain_empty", 32'(count), 0);
    step(0, 0, 0, 0, 0);
    chk("drain_release", 32'(wr_req_ready), 1);
    chk("drain_ack_off", 32'(drain_ack), 0);
    // underflow
    step(0, 0, 1, 0, 0);
    chk("uf_count", 32'(count), 0);
    chk("uf_err", 32'(err), 32'(ERR_EN));
    // random
    dr_lvl = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) dr_lvl = ~dr_lvl;
      step(1'($urandom_range(0, 1)), base + 32'($urandom_range(0, 7) << 4) + 32'($urandom_range(0, 15)),
           $urandom_range(0, 2) == 0, base + 32'($urandom_range(0, 7) << 4) + 32'($urandom_range(0, 15)), dr_lvl);
    end
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH && q.size() > 0; i++) step(0, 0, 1, 0, 0);
    // async reset mid-operation
    for (int i = 0; i < 3; i++) step(1, base + 32'h800 + 32'(i * 16), 0, 0, 0);
    chk("ar_count3", 32'(count), 3);
    @(negedge clk);
    wr_req_valid = 1'b0; wr_done = 1'b0; rd_check_addr = base + 32'h810;
    #1;
    chk("ar_pre_conflict", 32'(rd_conflict), 1);
    #1; rst = 1'b1; #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_empty", 32'(empty), 1);
    chk("ar_conflict", 32'(rd_conflict), 0);
    chk("ar_ready", 32'(wr_req_ready), 0);
    chk("ar_err", 32'(err), 0);
    @(negedge clk); rst = 1'b0;
    q.delete(); m_drain = 1'b0; m_err = 1'b0;
    step(1, base + 32'h900, 0, base + 32'h810, 0);
    step(0, 0, 0, base + 32'h900, 0);
    step(0, 0, 1, base + 32'h900, 0);
    step(0, 0, 0, base + 32'h900, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
